// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern mode encoding, default 640x480@60 timing
// and a small counter-window helper used by the timing decode.
package vga_pkg;

  // Width of the raster counters; totals up to 1024 fit.
  localparam int unsigned CNT_W = 10;

  // Pattern select encoding.
  localparam logic [1:0] MODE_BARS    = 2'd0;
  localparam logic [1:0] MODE_CHECKER = 2'd1;
  localparam logic [1:0] MODE_SCROLL  = 2'd2;
  localparam logic [1:0] MODE_SOLID   = 2'd3;

  // 640x480@60 on a 25 MHz pixel clock.
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // True when cnt < lim. Compared at 32 bits so a limit of 1024 still works.
  function automatic logic below(input logic [CNT_W-1:0] cnt, input int unsigned lim);
    int unsigned c;
    c = 32'(cnt);
    return c < lim;
  endfunction

  // True when lo <= cnt < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input int unsigned lo,
                                     input int unsigned hi);
    int unsigned c;
    c = 32'(cnt);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster timing: horizontal/vertical counters, active-area flag, sync decode,
// frame-origin flag and end-of-frame strobe. All decodes are combinational
// from the counter state; the consumer registers them.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk_25,
  input  logic             reset,
  output logic [CNT_W-1:0] counter_x,
  output logic [CNT_W-1:0] counter_y,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_origin,
  output logic             end_of_frame
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0] cnt_x_q, cnt_x_d;
  logic [CNT_W-1:0] cnt_y_q, cnt_y_d;
  logic             x_wrap, y_wrap;

  // Next raster position: X every clock, Y on the X wrap
  always_comb begin
    x_wrap  = (cnt_x_q == H_LAST);
    y_wrap  = (cnt_y_q == V_LAST);
    cnt_x_d = x_wrap ? '0 : cnt_x_q + CNT_W'(1);
    cnt_y_d = cnt_y_q;
    if (x_wrap) begin
      cnt_y_d = y_wrap ? '0 : cnt_y_q + CNT_W'(1);
    end
  end

  // Raster counter state
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      cnt_x_q <= '0;
      cnt_y_q <= '0;
    end else begin
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
    end
  end

  // Decode of the current position into active area, syncs and frame markers
  always_comb begin
    active       = below(cnt_x_q, H_ACTIVE) && below(cnt_y_q, V_ACTIVE);
    hsync        = in_window(cnt_x_q, H_SYNC_START, H_SYNC_START + H_SYNC) ? SYNC_POL
                                                                           : ~SYNC_POL;
    // Vertical sync keys off Y only, so it covers whole lines.
    vsync        = in_window(cnt_y_q, V_SYNC_START, V_SYNC_START + V_SYNC) ? SYNC_POL
                                                                           : ~SYNC_POL;
    frame_origin = (cnt_x_q == '0) && (cnt_y_q == '0);
    end_of_frame = x_wrap && y_wrap;
  end

  assign counter_x = cnt_x_q;
  assign counter_y = cnt_y_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source. Selects one of four patterns from the raster
// position, holds the pattern mode and frame count stable for a whole frame,
// and registers pixel, syncs, display-enable and frame-start together so the
// connector sees no skew between them.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned PIXEL_W     = 3,
  parameter int unsigned BAR_SHIFT   = 6,
  parameter int unsigned CHECK_SHIFT = 5
) (
  input  logic               clk_25,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] solid_color,
  output logic [PIXEL_W-1:0] pixel,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de,
  output logic               frame_start,
  output logic [CNT_W-1:0]   CounterX,
  output logic [CNT_W-1:0]   CounterY
);

  logic [CNT_W-1:0]   cnt_x, cnt_y;
  logic               active, hsync, vsync, frame_origin, end_of_frame;

  logic [1:0]         mode_q;
  logic [7:0]         frame_cnt_q;
  logic [PIXEL_W-1:0] pattern, pixel_d, pixel_q;
  logic               de_q, hsync_q, vsync_q, frame_start_q;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk_25       (clk_25),
    .reset        (reset),
    .counter_x    (cnt_x),
    .counter_y    (cnt_y),
    .active       (active),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_origin (frame_origin),
    .end_of_frame (end_of_frame)
  );

  // Mode and frame count change only on the last pixel of a frame, so the
  // first pixel of the next frame already uses the new values.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_BARS;
      frame_cnt_q <= '0;
    end else if (end_of_frame) begin
      mode_q      <= mode;
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Pattern value for the current position; blanked outside the active area
  always_comb begin
    pattern = '0;
    case (mode_q)
      MODE_BARS:    pattern = PIXEL_W'(cnt_x >> BAR_SHIFT);
      MODE_CHECKER: pattern = {PIXEL_W{cnt_x[CHECK_SHIFT] ^ cnt_y[CHECK_SHIFT]}};
      // Sum is truncated to the pixel width, giving the modulo wrap.
      MODE_SCROLL:  pattern = PIXEL_W'((cnt_x >> BAR_SHIFT) + CNT_W'(frame_cnt_q));
      MODE_SOLID:   pattern = solid_color;
      default:      pattern = '0;
    endcase
    pixel_d = active ? pattern : '0;
  end

  // Output registers: one clock after the counter state, all five aligned
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      pixel_q       <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      pixel_q       <= pixel_d;
      de_q          <= active;
      hsync_q       <= hsync;
      vsync_q       <= vsync;
      frame_start_q <= frame_origin;
    end
  end

  assign pixel       = pixel_q;
  assign de          = de_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign frame_start = frame_start_q;
  assign CounterX    = cnt_x;
  assign CounterY    = cnt_y;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster (100x50 clocks per frame) so
// several frames fit in a short run. A position/frame model predicts every
// output on every clock; directed literal checks pin that model.
module tb_vga_pattern_gen;

  localparam int HA = 80;
  localparam int HF = 4;
  localparam int HS = 6;
  localparam int HB = 10;
  localparam int VA = 40;
  localparam int VF = 2;
  localparam int VS = 3;
  localparam int VB = 5;
  localparam int PW = 3;
  localparam int BS = 3;
  localparam int CS = 3;

  localparam int HT    = HA + HF + HS + HB;  // 100
  localparam int VT    = VA + VF + VS + VB;  // 50
  localparam int FRAME = HT * VT;            // 5000
  localparam int BAR_W = 1 << BS;
  localparam int CHK   = 1 << CS;
  localparam int NCOL  = 1 << PW;

  logic          clk_25 = 1'b0;
  logic          reset  = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [PW-1:0] solid_color = '0;
  logic [PW-1:0] pixel;
  logic          hsync_out, vsync_out, de, frame_start;
  logic [9:0]    CounterX, CounterY;

  int vectors = 0;
  int miscompares = 0;

  // Model state: k = posedges since reset release.
  int k = 0;
  int mode_of_frame [int];
  int last_solid = 0;
  int m_p, m_x, m_y, m_f, m_k;

  vga_pattern_gen #(
    .H_ACTIVE    (HA),
    .H_FP        (HF),
    .H_SYNC      (HS),
    .H_BP        (HB),
    .V_ACTIVE    (VA),
    .V_FP        (VF),
    .V_SYNC      (VS),
    .V_BP        (VB),
    .SYNC_POL    (1'b0),
    .PIXEL_W     (PW),
    .BAR_SHIFT   (BS),
    .CHECK_SHIFT (CS)
  ) dut (
    .clk_25      (clk_25),
    .reset       (reset),
    .mode        (mode),
    .solid_color (solid_color),
    .pixel       (pixel),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .de          (de),
    .frame_start (frame_start),
    .CounterX    (CounterX),
    .CounterY    (CounterY)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_pixel(input int x, input int y, input int f, input int m,
                                   input int solid);
    if (x >= HA || y >= VA) return 0;
    case (m)
      0:       return (x / BAR_W) % NCOL;
      1:       return (((x / CHK) + (y / CHK)) % 2 == 1) ? NCOL - 1 : 0;
      2:       return ((x / BAR_W) + (f % 256)) % NCOL;
      default: return solid;
    endcase
  endfunction

  // Model: count edges, capture mode at each frame boundary, capture solid colour
  always @(posedge clk_25) begin
    if (reset) begin
      k = 0;
      mode_of_frame.delete();
      mode_of_frame[0] = 0;
    end else begin
      k = k + 1;
      last_solid = int'(solid_color);
      if (k % FRAME == 0) mode_of_frame[k / FRAME] = int'(mode);
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk_25) begin
    if (reset) begin
      check("reset pixel", pixel, 0);
      check("reset de", de, 0);
      check("reset hsync", hsync_out, 1);
      check("reset vsync", vsync_out, 1);
      check("reset frame_start", frame_start, 0);
      check("reset CounterX", CounterX, 0);
      check("reset CounterY", CounterY, 0);
    end else if (k >= 1) begin
      m_p = k - 1;
      m_f = m_p / FRAME;
      m_x = (m_p % FRAME) % HT;
      m_y = (m_p % FRAME) / HT;
      m_k = k % FRAME;
      check($sformatf("pixel(%0d,%0d) frame %0d", m_x, m_y, m_f), pixel,
            exp_pixel(m_x, m_y, m_f, mode_of_frame[m_f], last_solid));
      check($sformatf("de(%0d,%0d)", m_x, m_y), de, (m_x < HA) && (m_y < VA));
      check($sformatf("hsync(%0d,%0d)", m_x, m_y), hsync_out,
            (m_x >= HA + HF && m_x < HA + HF + HS) ? 0 : 1);
      check($sformatf("vsync(%0d,%0d)", m_x, m_y), vsync_out,
            (m_y >= VA + VF && m_y < VA + VF + VS) ? 0 : 1);
      check($sformatf("frame_start(%0d,%0d)", m_x, m_y), frame_start, (m_x == 0) && (m_y == 0));
      check("CounterX", CounterX, m_k % HT);
      check("CounterY", CounterY, m_k / HT);
    end
  end

  // Advance to the falling edge whose registered outputs show position (x,y)
  task automatic wait_out(input int x, input int y);
    bit found = 1'b0;
    for (int n = 0; n < FRAME + 10; n++) begin
      @(negedge clk_25);
      if (k >= 1 && ((k - 1) % FRAME) == y * HT + x) begin
        found = 1'b1;
        break;
      end
    end
    check($sformatf("reached (%0d,%0d)", x, y), found, 1);
  endtask

  initial begin
    int hs_low, hs_first, vs_low, vs_first, de_high, fs_cnt, n;
    bit got;
    mode_of_frame[0] = 0;

    // Reset held for 5 clocks
    repeat (5) @(negedge clk_25);
    check("held reset pixel", pixel, 0);
    check("held reset de", de, 0);
    check("held reset hsync", hsync_out, 1);
    check("held reset vsync", vsync_out, 1);
    #5 reset = 1'b0;
    @(negedge clk_25);
    check("first edge frame_start", frame_start, 1);
    check("first edge de", de, 1);
    check("first edge pixel", pixel, 0);

    // Frame 0: bars
    wait_out(8, 0);   check("bars x=8", pixel, 1);
    wait_out(56, 0);  check("bars x=56", pixel, 7);
    wait_out(64, 0);  check("bars x=64 wrap", pixel, 0);
    wait_out(90, 0);  check("bars blank pixel", pixel, 0);
    check("bars blank de", de, 0);
    #5 mode = 2'd1;

    // Frame 1: checker
    wait_out(0, 0);   check("checker (0,0)", pixel, 0);
    wait_out(8, 0);   check("checker (8,0)", pixel, 7);
    wait_out(0, 8);   check("checker (0,8)", pixel, 7);
    wait_out(8, 8);   check("checker (8,8)", pixel, 0);
    #5 mode = 2'd2;

    // Frame 2: scrolling bars, plus a full-frame timing scan
    wait_out(0, 0);
    hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1; de_high = 0; fs_cnt = 0;
    check("scroll frame 2 x=0", pixel, 2);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk_25);
      if (i == 8) check("scroll frame 2 x=8", pixel, 3);
      if (hsync_out == 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_low++;
      end
      if (vsync_out == 1'b0) begin
        if (vs_first < 0) vs_first = i;
        vs_low++;
      end
      if (de) de_high++;
      if (frame_start) fs_cnt++;
    end
    check("hsync first low x", hs_first, HA + HF);
    check("hsync low clocks/frame", hs_low, HS * VT);
    check("vsync first low clock", vs_first, (VA + VF) * HT);
    check("vsync low clocks", vs_low, VS * HT);
    check("de high clocks/frame", de_high, HA * VA);
    check("frame_start pulses/frame", fs_cnt, 1);
    @(negedge clk_25);
    check("frame period", frame_start, 1);
    check("scroll frame 3 x=0", pixel, 3);

    // Frame 4: mode switch mid-frame must not affect it
    wait_out(0, 0);   check("scroll frame 4 x=0", pixel, 4);
    wait_out(10, 20);
    #5 mode = 2'd3;
    solid_color = 3'd5;
    wait_out(16, 30); check("frame 4 unchanged", pixel, 6);

    // Frame 5: solid colour, sampled every clock
    wait_out(0, 0);   check("solid first pixel", pixel, 5);
    wait_out(40, 5);  check("solid mid", pixel, 5);
    #5 solid_color = 3'd2;
    @(negedge clk_25);
    check("solid follows input", pixel, 2);

    // Asynchronous reset mid-frame
    wait_out(30, 20);
    #5 reset = 1'b1;
    #1;
    check("async reset pixel", pixel, 0);
    check("async reset de", de, 0);
    check("async reset hsync", hsync_out, 1);
    check("async reset vsync", vsync_out, 1);
    check("async reset frame_start", frame_start, 0);
    check("async reset CounterX", CounterX, 0);
    check("async reset CounterY", CounterY, 0);
    repeat (3) @(negedge clk_25);
    #5 reset = 1'b0;
    @(negedge clk_25);
    check("restart frame_start", frame_start, 1);
    check("restart de", de, 1);
    check("restart pixel", pixel, 0);
    n = 0;
    got = 1'b0;
    while (n < FRAME + 100 && !got) begin
      @(negedge clk_25);
      n++;
      if (n == 8) check("bars after reset x=8", pixel, 1);
      if (frame_start) got = 1'b1;
    end
    check("period after reset", n, FRAME);
    check("solid frame after reset", pixel, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
